// File: rtl/wt_mem_arbiter_if.sv
// Cache/memory-side bundle for the write-through memory arbiter.
// The arbiter connects via the slave modport; caches and memory (or a bench) via master.
interface wt_mem_arbiter_if #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned TidWidth  = 2,
    parameter int unsigned RtrnWidth = 128
);
    localparam int unsigned BeWidth = DataWidth / 8;

    logic                 icache_data_req_i;
    logic                 icache_data_ack_o;
    logic [AddrWidth-1:0] icache_addr_i;
    logic [TidWidth-1:0]  icache_tid_i;

    logic                 dcache_data_req_i;
    logic                 dcache_data_ack_o;
    logic [AddrWidth-1:0] dcache_addr_i;
    logic                 dcache_we_i;
    logic [DataWidth-1:0] dcache_wdata_i;
    logic [BeWidth-1:0]   dcache_be_i;
    logic [TidWidth-1:0]  dcache_tid_i;

    logic                 mem_req_valid_o;
    logic                 mem_req_ready_i;
    logic                 mem_req_src_o;
    logic [AddrWidth-1:0] mem_req_addr_o;
    logic                 mem_req_we_o;
    logic [DataWidth-1:0] mem_req_wdata_o;
    logic [BeWidth-1:0]   mem_req_be_o;
    logic [TidWidth-1:0]  mem_req_tid_o;

    logic                 mem_rtrn_valid_i;
    logic                 mem_rtrn_src_i;
    logic [TidWidth-1:0]  mem_rtrn_tid_i;
    logic [RtrnWidth-1:0] mem_rtrn_data_i;

    logic                 icache_rtrn_vld_o;
    logic                 dcache_rtrn_vld_o;
    logic [TidWidth-1:0]  rtrn_tid_o;
    logic [RtrnWidth-1:0] rtrn_data_o;
    logic                 err_o;

    modport slave (
        input  icache_data_req_i, icache_addr_i, icache_tid_i,
        input  dcache_data_req_i, dcache_addr_i, dcache_we_i, dcache_wdata_i, dcache_be_i,
        input  dcache_tid_i,
        input  mem_req_ready_i,
        input  mem_rtrn_valid_i, mem_rtrn_src_i, mem_rtrn_tid_i, mem_rtrn_data_i,
        output icache_data_ack_o, dcache_data_ack_o,
        output mem_req_valid_o, mem_req_src_o, mem_req_addr_o, mem_req_we_o,
        output mem_req_wdata_o, mem_req_be_o, mem_req_tid_o,
        output icache_rtrn_vld_o, dcache_rtrn_vld_o, rtrn_tid_o, rtrn_data_o, err_o
    );

    modport master (
        output icache_data_req_i, icache_addr_i, icache_tid_i,
        output dcache_data_req_i, dcache_addr_i, dcache_we_i, dcache_wdata_i, dcache_be_i,
        output dcache_tid_i,
        output mem_req_ready_i,
        output mem_rtrn_valid_i, mem_rtrn_src_i, mem_rtrn_tid_i, mem_rtrn_data_i,
        input  icache_data_ack_o, dcache_data_ack_o,
        input  mem_req_valid_o, mem_req_src_o, mem_req_addr_o, mem_req_we_o,
        input  mem_req_wdata_o, mem_req_be_o, mem_req_tid_o,
        input  icache_rtrn_vld_o, dcache_rtrn_vld_o, rtrn_tid_o, rtrn_data_o, err_o
    );
endinterface

// File: rtl/wt_mem_arbiter.sv
// Memory-side front end of the write-through cache subsystem: merges I$ and D$ requests
// into one registered request channel, limits in-flight requests per source and routes
// returns back by source bit.
module wt_mem_arbiter #(
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned TidWidth       = 2,
    parameter int unsigned RtrnWidth      = 128,
    parameter int unsigned MaxOutstanding = 4
) (
    input logic               clk_i,
    input logic               rst_i,
    wt_mem_arbiter_if.slave   bus
);
    localparam int unsigned BeWidth = DataWidth / 8;
    localparam logic [3:0]  MaxCnt  = 4'(MaxOutstanding);

    typedef struct packed {
        logic                 src;
        logic [AddrWidth-1:0] addr;
        logic                 we;
        logic [DataWidth-1:0] wdata;
        logic [BeWidth-1:0]   be;
        logic [TidWidth-1:0]  tid;
    } req_t;

    req_t       req_q, req_d;
    logic       valid_q, valid_d;
    logic       rr_q, rr_d;
    logic [3:0] icnt_q, icnt_d;
    logic [3:0] dcnt_q, dcnt_d;
    logic       err_q, err_d;

    logic slot_free, i_elig, d_elig, i_gnt, d_gnt;
    logic i_rtrn, d_rtrn, i_dec, d_dec;

    // Grant selection, output register load/drain, round-robin pointer update.
    always_comb begin
        slot_free = !valid_q || bus.mem_req_ready_i;
        i_elig    = bus.icache_data_req_i && (icnt_q < MaxCnt);
        d_elig    = bus.dcache_data_req_i && (dcnt_q < MaxCnt);
        i_gnt     = 1'b0;
        d_gnt     = 1'b0;
        rr_d      = rr_q;
        req_d     = req_q;
        valid_d   = valid_q && !bus.mem_req_ready_i;

        if (slot_free) begin
            if (i_elig && d_elig) begin
                // Contested: pointer's source wins, pointer flips to the loser.
                i_gnt = !rr_q;
                d_gnt = rr_q;
                rr_d  = !rr_q;
            end else begin
                i_gnt = i_elig;
                d_gnt = d_elig;
            end
        end

        if (i_gnt) begin
            valid_d   = 1'b1;
            req_d     = '0;
            req_d.addr = bus.icache_addr_i;
            req_d.tid  = bus.icache_tid_i;
        end else if (d_gnt) begin
            valid_d    = 1'b1;
            req_d.src   = 1'b1;
            req_d.addr  = bus.dcache_addr_i;
            req_d.we    = bus.dcache_we_i;
            req_d.wdata = bus.dcache_wdata_i;
            req_d.be    = bus.dcache_be_i;
            req_d.tid   = bus.dcache_tid_i;
        end
    end

    // Outstanding counters and sticky error; a return to an empty counter flags an error.
    always_comb begin
        i_rtrn = bus.mem_rtrn_valid_i && !bus.mem_rtrn_src_i;
        d_rtrn = bus.mem_rtrn_valid_i && bus.mem_rtrn_src_i;
        i_dec  = i_rtrn && (icnt_q != 4'd0);
        d_dec  = d_rtrn && (dcnt_q != 4'd0);
        icnt_d = icnt_q + {3'b000, i_gnt} - {3'b000, i_dec};
        dcnt_d = dcnt_q + {3'b000, d_gnt} - {3'b000, d_dec};
        err_d  = err_q || (i_rtrn && (icnt_q == 4'd0)) || (d_rtrn && (dcnt_q == 4'd0));
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_q   <= '0;
            valid_q <= 1'b0;
            rr_q    <= 1'b0;
            icnt_q  <= 4'd0;
            dcnt_q  <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            req_q   <= req_d;
            valid_q <= valid_d;
            rr_q    <= rr_d;
            icnt_q  <= icnt_d;
            dcnt_q  <= dcnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.icache_data_ack_o = i_gnt;
    assign bus.dcache_data_ack_o = d_gnt;
    assign bus.mem_req_valid_o   = valid_q;
    assign bus.mem_req_src_o     = req_q.src;
    assign bus.mem_req_addr_o    = req_q.addr;
    assign bus.mem_req_we_o      = req_q.we;
    assign bus.mem_req_wdata_o   = req_q.wdata;
    assign bus.mem_req_be_o      = req_q.be;
    assign bus.mem_req_tid_o     = req_q.tid;
    assign bus.icache_rtrn_vld_o = i_rtrn;
    assign bus.dcache_rtrn_vld_o = d_rtrn;
    assign bus.rtrn_tid_o        = bus.mem_rtrn_tid_i;
    assign bus.rtrn_data_o       = bus.mem_rtrn_data_i;
    assign bus.err_o             = err_q;
endmodule

// File: tb/tb_wt_mem_arbiter.sv
// Bench for wt_mem_arbiter: directed scenarios plus random traffic, all checked against a
// transaction-level model (pending requests, one-entry slot, per-source in-flight queues).
module tb_wt_mem_arbiter;
    localparam int unsigned Max = 4;

    typedef struct packed {
        logic        src;
        logic [63:0] addr;
        logic        we;
        logic [63:0] wdata;
        logic [7:0]  be;
        logic [1:0]  tid;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wt_mem_arbiter_if #(.AddrWidth(64), .DataWidth(64), .TidWidth(2), .RtrnWidth(128)) ifc ();

    wt_mem_arbiter #(
        .AddrWidth(64), .DataWidth(64), .TidWidth(2), .RtrnWidth(128), .MaxOutstanding(Max)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifc)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model state.
    bit         i_pend, d_pend;
    req_t       i_req, d_req;
    bit         slot_v;
    req_t       slot;
    int         icnt, dcnt;
    bit         prio_d;   // 1: D$ wins the next contested grant
    bit         err_m;
    logic [1:0] acc_i[$];
    logic [1:0] acc_d[$];

    // Stimulus knobs (percent probabilities) and a one-shot forced return.
    int         p_i, p_d, p_rdy, p_rt;
    bit         force_rt;
    bit         force_src;
    logic [1:0] force_tid;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        i_pend = 0; d_pend = 0; slot_v = 0; icnt = 0; dcnt = 0; prio_d = 0; err_m = 0;
        acc_i.delete(); acc_d.delete();
    endtask

    task automatic drive_idle();
        ifc.icache_data_req_i = 0; ifc.icache_addr_i = '0; ifc.icache_tid_i = '0;
        ifc.dcache_data_req_i = 0; ifc.dcache_addr_i = '0; ifc.dcache_we_i = 0;
        ifc.dcache_wdata_i = '0; ifc.dcache_be_i = '0; ifc.dcache_tid_i = '0;
        ifc.mem_req_ready_i = 0; ifc.mem_rtrn_valid_i = 0; ifc.mem_rtrn_src_i = 0;
        ifc.mem_rtrn_tid_i = '0; ifc.mem_rtrn_data_i = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        drive_idle();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", ifc.mem_req_valid_o, 0);
        chk("rst_iack", ifc.icache_data_ack_o, 0);
        chk("rst_dack", ifc.dcache_data_ack_o, 0);
        chk("rst_err", ifc.err_o, 0);
        chk("rst_addr", ifc.mem_req_addr_o, 0);
        chk("rst_src", ifc.mem_req_src_o, 0);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic check_slot();
        chk("valid", ifc.mem_req_valid_o, slot_v);
        chk("err", ifc.err_o, err_m);
        if (slot_v) begin
            chk("src", ifc.mem_req_src_o, slot.src);
            chk("addr", ifc.mem_req_addr_o, slot.addr);
            chk("we", ifc.mem_req_we_o, slot.we);
            chk("wdata", ifc.mem_req_wdata_o, slot.wdata);
            chk("be", ifc.mem_req_be_o, slot.be);
            chk("tid", ifc.mem_req_tid_o, slot.tid);
        end
    endtask

    // One clock cycle: drive inputs, check combinational outputs, advance model and clock,
    // then check registered outputs.
    task automatic step();
        bit           rt_v, rt_src, rdy, free, ie, de, gi, gd;
        logic [1:0]   rt_tid;
        logic [127:0] rt_data;

        if (!i_pend && $urandom_range(99) < p_i) begin
            i_pend = 1;
            i_req = '0;
            i_req.addr = {$urandom, $urandom};
            i_req.tid = 2'($urandom);
        end
        if (!d_pend && $urandom_range(99) < p_d) begin
            d_pend = 1;
            d_req.src = 1;
            d_req.addr = {$urandom, $urandom};
            d_req.we = 1'($urandom);
            d_req.wdata = {$urandom, $urandom};
            d_req.be = 8'($urandom);
            d_req.tid = 2'($urandom);
        end

        rt_v = 0; rt_src = 0; rt_tid = '0;
        if (force_rt) begin
            rt_v = 1; rt_src = force_src; rt_tid = force_tid; force_rt = 0;
            if (rt_src && acc_d.size() > 0) void'(acc_d.pop_front());
            if (!rt_src && acc_i.size() > 0) void'(acc_i.pop_front());
        end else if ($urandom_range(99) < p_rt) begin
            rt_src = 1'($urandom);
            if (rt_src && acc_d.size() > 0) begin rt_v = 1; rt_tid = acc_d.pop_front(); end
            if (!rt_src && acc_i.size() > 0) begin rt_v = 1; rt_tid = acc_i.pop_front(); end
        end
        rt_data = {$urandom, $urandom, $urandom, $urandom};
        rdy = ($urandom_range(99) < p_rdy);

        ifc.icache_data_req_i = i_pend;
        ifc.icache_addr_i = i_req.addr;
        ifc.icache_tid_i = i_req.tid;
        ifc.dcache_data_req_i = d_pend;
        ifc.dcache_addr_i = d_req.addr;
        ifc.dcache_we_i = d_req.we;
        ifc.dcache_wdata_i = d_req.wdata;
        ifc.dcache_be_i = d_req.be;
        ifc.dcache_tid_i = d_req.tid;
        ifc.mem_req_ready_i = rdy;
        ifc.mem_rtrn_valid_i = rt_v;
        ifc.mem_rtrn_src_i = rt_src;
        ifc.mem_rtrn_tid_i = rt_tid;
        ifc.mem_rtrn_data_i = rt_data;
        #1;

        free = !slot_v || rdy;
        ie = i_pend && icnt < Max;
        de = d_pend && dcnt < Max;
        gi = free && ie && (!de || !prio_d);
        gd = free && de && (!ie || prio_d);
        chk("iack", ifc.icache_data_ack_o, gi);
        chk("dack", ifc.dcache_data_ack_o, gd);
        chk("irtrn", ifc.icache_rtrn_vld_o, rt_v && !rt_src);
        chk("drtrn", ifc.dcache_rtrn_vld_o, rt_v && rt_src);
        if (rt_v) begin
            chk("rtid", ifc.rtrn_tid_o, rt_tid);
            chk("rdata", ifc.rtrn_data_o, rt_data);
        end

        if (slot_v && rdy) begin
            if (slot.src) acc_d.push_back(slot.tid);
            else acc_i.push_back(slot.tid);
            slot_v = 0;
        end
        if (rt_v) begin
            if (rt_src) begin if (dcnt == 0) err_m = 1; else dcnt--; end
            else begin if (icnt == 0) err_m = 1; else icnt--; end
        end
        if (ie && de && (gi || gd)) prio_d = gi;
        if (gi) begin slot = i_req; slot_v = 1; icnt++; i_pend = 0; end
        if (gd) begin slot = d_req; slot_v = 1; dcnt++; d_pend = 0; end

        @(posedge clk);
        #1;
        check_slot();
    endtask

    task automatic knobs(input int pi, input int pd, input int prdy, input int prt);
        p_i = pi; p_d = pd; p_rdy = prdy; p_rt = prt;
    endtask

    initial begin
        force_rt = 0; force_src = 0; force_tid = '0;
        drive_idle();
        model_clear();
        do_reset();

        // Single I$ refill request.
        knobs(0, 0, 100, 0);
        i_pend = 1; i_req = '0; i_req.addr = 64'h8000_0040;
        repeat (3) step();

        // Both caches requesting continuously: strict alternation from I$.
        do_reset();
        knobs(100, 100, 100, 0);
        repeat (8) step();

        // D$ write stalled by memory, then drain with same-cycle reload.
        do_reset();
        knobs(0, 0, 0, 0);
        d_pend = 1; d_req = '0; d_req.src = 1; d_req.we = 1;
        d_req.wdata = 64'hDEAD_BEEF; d_req.be = 8'h0F; d_req.tid = 2'd1;
        step();
        knobs(0, 100, 0, 0);
        repeat (3) step();
        knobs(0, 100, 100, 0);
        repeat (2) step();

        // Fill both limits, then free one D$ slot with a return.
        do_reset();
        knobs(100, 100, 100, 0);
        repeat (12) step();
        force_rt = 1; force_src = 1; force_tid = 2'd2;
        repeat (3) step();

        // Unmatched return sets a sticky error; async reset clears it mid-stall.
        do_reset();
        knobs(0, 0, 100, 0);
        force_rt = 1; force_src = 0; force_tid = 2'd1;
        step();
        knobs(100, 100, 0, 0);
        repeat (4) step();
        #2;
        rst = 1;
        #1;
        chk("async_valid", ifc.mem_req_valid_o, 0);
        chk("async_err", ifc.err_o, 0);
        drive_idle();
        model_clear();
        repeat (2) @(negedge clk);
        rst = 0;
        knobs(0, 100, 100, 0);
        repeat (8) step();

        // Random traffic.
        do_reset();
        knobs(60, 60, 70, 40);
        repeat (2000) step();
        knobs(90, 90, 90, 15);
        repeat (1000) step();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/wt_mem_arbiter.md
Name: wt_mem_arbiter

Overview:
- Memory-side front end of the write-through cache subsystem.
- Accepts I$ refill requests and D$ read/write/AMO requests over the caches' req/ack interface and merges them into one registered outbound request channel (valid/ready).
- Routes returns back to the issuing cache by source bit.
- Enforces a per-source outstanding-transaction limit, with round-robin fairness between the two caches.

Parameters:
AddrWidth, 64, physical address width of requests
DataWidth, 64, D$ write data width; D$ byte-enable width is DataWidth/8
TidWidth, 2, transaction ID width, passed through unchanged
RtrnWidth, 128, return data width (one cache line beat)
MaxOutstanding, 4, maximum in-flight requests per source; legal range 1..15

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
icache_data_req_i  in  1  I$ request; held high until acknowledged
icache_data_ack_o  out  1  I$ request accepted this cycle
icache_addr_i  in  AddrWidth  I$ refill address
icache_tid_i  in  TidWidth  I$ transaction ID
dcache_data_req_i  in  1  D$ request; held high until acknowledged
dcache_data_ack_o  out  1  D$ request accepted this cycle
dcache_addr_i  in  AddrWidth  D$ address
dcache_we_i  in  1  1=write, 0=read
dcache_wdata_i  in  DataWidth  D$ write data
dcache_be_i  in  DataWidth/8  D$ byte enables
dcache_tid_i  in  TidWidth  D$ transaction ID
mem_req_valid_o  out  1  outbound request valid
mem_req_ready_i  in  1  memory accepts request
mem_req_src_o  out  1  0=I$, 1=D$
mem_req_addr_o  out  AddrWidth  address
mem_req_we_o  out  1  write flag
mem_req_wdata_o  out  DataWidth  write data
mem_req_be_o  out  DataWidth/8  byte enables
mem_req_tid_o  out  TidWidth  transaction ID
mem_rtrn_valid_i  in  1  return valid; always accepted, no backpressure
mem_rtrn_src_i  in  1  return destination
mem_rtrn_tid_i  in  TidWidth  return ID
mem_rtrn_data_i  in  RtrnWidth  return data
icache_rtrn_vld_o  out  1  return for I$
dcache_rtrn_vld_o  out  1  return for D$
rtrn_tid_o  out  TidWidth  return ID, shared by both caches
rtrn_data_o  out  RtrnWidth  return data, shared by both caches
err_o  out  1  sticky protocol error flag

Behaviour:
- Reset values: all outputs 0, both outstanding counters 0, rr pointer 0 (I$ has first priority), output register empty.
- The output register (one entry) is free when `!mem_req_valid_o` or `mem_req_ready_i`; load and drain in the same cycle is allowed.
- Source eligibility: `data_req_i` is high and its outstanding count < MaxOutstanding.
- Grant, combinational, only when the register is free:
  - If only one source is eligible, grant it.
  - If both are eligible, grant the rr pointer's source; the pointer then moves to the other source.
  - The pointer changes only on a grant.
- The granted source's `ack_o` pulses for 1 cycle in the grant cycle.
- The payload is registered, and `mem_req_valid_o` rises the next cycle (one-cycle latency from req to valid).
- An I$ grant drives `we=0`, `wdata=0`, `be=0`, `src=0`.
- The payload stays stable while `valid && !ready`.
- The outstanding counter increments on grant and decrements on a return with the matching `src`.
  - A simultaneous grant and return for the same source leaves the counter unchanged.
  - Counter width is 4 bits.
- Writes also count as outstanding; memory returns a write ack on `mem_rtrn` carrying the same tid.
- Returns are combinational passthrough:
  - `icache_rtrn_vld_o = valid & !src`, `dcache_rtrn_vld_o = valid & src`.
  - `rtrn_tid_o` and `rtrn_data_o` are driven directly from the inputs.
- A return for a source whose counter is 0 sets `err_o` (sticky until reset); that counter stays at 0 (no underflow).
- A request that is not granted stays pending; the arbiter never drops or reorders a request within a source.
- Reset mid-operation: the register is invalidated and the counters are cleared immediately (async). In-flight memory transactions are the memory side's responsibility.

Test Plan:
- Single I$ req, addr=0x8000_0040, tid=0, ready=1 → ack at cycle 0; at cycle 1 valid=1, src=0, addr=0x8000_0040, we=0; I$ count=1.
- Both reqs high continuously, ready=1 → grants alternate I$, D$, I$, D$ starting with I$ after reset.
- D$ write: wdata=0xDEAD_BEEF, be=0x0F, ready held 0 for 3 cycles → payload stable, no new ack; ready=1 drains, and a new ack occurs in that same cycle.
- D$ issues 4 requests with no returns → 5th D$ req not acked while I$ still granted. Return src=1 tid=2 → dcache_rtrn_vld_o=1, rtrn_tid_o=2, and the D$ req is granted next cycle.
- At count=MaxOutstanding, a grant and a return for the same source in the same cycle are impossible; at count=2, the simultaneous case leaves the count at 2.
- Return src=0 with I$ count 0 → err_o=1 and stays 1. Assert rst_i mid-stall → valid=0, err_o=0, counters 0 asynchronously.
